axi_aw_rr_allocator: RTL and testbench
======================================

Name: axi_aw_rr_allocator

Overview:
- Write-address (AW) stage of one master-side port of the AXI node.
- Round-robin arbitrates AW requests from N_TARG_PORT initiator ports and forwards the winner's AW beat downstream.
- On every accepted AW beat, pushes the winner ID {binary, one-hot} into the write-data allocator's master-ID FIFO. This lets W beats be steered in AW order.
- Sits directly upstream of the W-channel allocator and feeds its push_ID/ID/grant interface.

Parameters:
- AXI_ADDRESS_W, 32, address width
- AXI_ID_W, 4, AW ID width, passed through unchanged
- AXI_USER_W, 6, AW user width
- N_TARG_PORT, 7, number of initiator ports
- LOG_N_TARG, $clog2(N_TARG_PORT), binary index width
- AW_ATTR_W, 21, packed {size[3], burst[2], lock[1], cache[4], prot[3], region[4], qos[4]}; qos is the LSB nibble

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- awid_i  in  N_TARG_PORT*AXI_ID_W  per-port AW ID
- awaddr_i  in  N_TARG_PORT*AXI_ADDRESS_W  per-port address
- awlen_i  in  N_TARG_PORT*8  per-port burst length
- awattr_i  in  N_TARG_PORT*AW_ATTR_W  per-port packed attributes
- awuser_i  in  N_TARG_PORT*AXI_USER_W  per-port user
- awvalid_i  in  N_TARG_PORT  per-port valid
- awready_o  out  N_TARG_PORT  per-port ready, one-hot or zero
- awid_o, awaddr_o, awlen_o, awattr_o, awuser_o  out  widths as above  selected AW beat
- awvalid_o  out  1  downstream valid
- awready_i  in  1  downstream ready
- push_ID_o  out  1  ID FIFO push strobe
- ID_o  out  LOG_N_TARG+N_TARG_PORT  {winner binary index, winner one-hot}
- grant_FIFO_ID_i  in  1  ID FIFO has space

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset effects: on any rising edge with rst=1, the FSM goes to IDLE, rr_ptr goes to 0 and the lock index is cleared.
  - All outputs (awvalid_o, awready_o, push_ID_o, ID_o, payload) read 0 while in IDLE with no request.
  - A reset mid-HOLD abandons the beat; no push is issued.
- Round-robin search: starts at rr_ptr and wraps modulo N_TARG_PORT. The first port with awvalid_i=1 wins.
- State IDLE:
  - Eligible only when grant_FIFO_ID_i=1 and |awvalid_i=1. Otherwise awvalid_o=0, awready_o=0, push_ID_o=0.
  - When eligible, the winner w is selected combinationally in the same cycle (zero latency): awvalid_o=1, payload muxed from w, ID_o={w, 1<<w}.
  - If awready_i=1 (handshake): awready_o[w]=1, push_ID_o=1, rr_ptr <= (w+1) mod N_TARG_PORT, stay in IDLE.
  - Else: lock_idx <= w, go to HOLD.
- State HOLD:
  - awvalid_o=1; payload and ID_o are taken from lock_idx. No re-arbitration, so output stays stable per AXI.
  - On awready_i=1: awready_o[lock_idx]=1, push_ID_o=1, rr_ptr <= lock_idx+1 mod N, go to IDLE.
  - grant_FIFO_ID_i is ignored here: space was confirmed on entry and this block is the only pusher.
- Handshake rules:
  - push_ID_o equals awvalid_o & awready_i; exactly one push per accepted AW beat.
  - awready_o is never asserted for more than one port and never without awready_i.
- Wrap: w = N_TARG_PORT-1 sets rr_ptr to 0.
- Non-power-of-two N: indices at or above N_TARG_PORT are never selected.
- FIFO full: no AW is presented, even if awready_i=1.
- Simultaneous requests: a port that wins moves to lowest priority. Back-to-back handshakes reach all requesters within N beats.
- Throughput: one AW beat per cycle when awready_i and FIFO grant are held high.

Optional Feature:
- Macro: AXI_AW_QOS_ARB_EN.
- Defined:
  - In IDLE, only requesters whose qos equals the maximum qos among valid requesters are eligible.
  - Round-robin from rr_ptr applies among those tied ports.
  - HOLD behaviour is unchanged.
- Undefined: qos is passed through only and has no effect on arbitration.

Test Plan:
- Reset: N=4, rst=1 for 2 cycles with awvalid_i=4'b1111 -> awvalid_o=0, awready_o=0, push_ID_o=0. First grant after reset goes to port 0 with ID_o={2'd0, 4'b0001}.
- Round robin: awvalid_i=4'b1111, awready_i=1, grant=1 for 4 cycles -> winners 0,1,2,3, push_ID_o high every cycle, ID_o one-hot 0001,0010,0100,1000.
- Stall and hold: port 2 only valid, awready_i=0 for 3 cycles, then port 0 raises valid -> payload and ID stay on port 2 until awready_i=1. One push occurs, then port 0 wins next.
- FIFO full: grant_FIFO_ID_i=0 with awvalid_i=4'b0100 -> awvalid_o=0 and no push. Raising grant gives awvalid_o=1 in the same cycle.
- Reset mid-HOLD: port 1 locked with awready_i=0, assert rst -> next cycle IDLE, rr_ptr=0, no push_ID_o pulse.
- QoS (macro defined): ports 0/3 valid with qos 2/9 -> port 3 wins. With both at qos 9 and rr_ptr=0 -> port 0 wins first, then port 3.

Source files
------------

// File: rtl/axi_aw_rr_allocator.sv
// AW-channel round-robin allocator for one master port. Each accepted beat pushes its winner ID into the W-channel ID FIFO.
// Define AXI_AW_QOS_ARB_EN to restrict arbitration to the highest-qos valid requesters.
module axi_aw_rr_allocator #(
  parameter int unsigned AXI_ADDRESS_W = 32,
  parameter int unsigned AXI_ID_W      = 4,
  parameter int unsigned AXI_USER_W    = 6,
  parameter int unsigned N_TARG_PORT   = 7,
  parameter int unsigned LOG_N_TARG    = $clog2(N_TARG_PORT),
  parameter int unsigned AW_ATTR_W     = 21
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_TARG_PORT*AXI_ID_W-1:0]      awid_i,
  input  logic [N_TARG_PORT*AXI_ADDRESS_W-1:0] awaddr_i,
  input  logic [N_TARG_PORT*8-1:0]             awlen_i,
  input  logic [N_TARG_PORT*AW_ATTR_W-1:0]     awattr_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]    awuser_i,
  input  logic [N_TARG_PORT-1:0]               awvalid_i,
  output logic [N_TARG_PORT-1:0]               awready_o,
  output logic [AXI_ID_W-1:0]                  awid_o,
  output logic [AXI_ADDRESS_W-1:0]             awaddr_o,
  output logic [7:0]                           awlen_o,
  output logic [AW_ATTR_W-1:0]                 awattr_o,
  output logic [AXI_USER_W-1:0]                awuser_o,
  output logic                                 awvalid_o,
  input  logic                                 awready_i,
  output logic                                 push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]    ID_o,
  input  logic                                 grant_FIFO_ID_i
);

  localparam int unsigned QOS_W = 4;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [LOG_N_TARG-1:0]   rr_ptr, rr_ptr_nxt;
  logic [LOG_N_TARG-1:0]   lock_idx, lock_idx_nxt;
  logic [N_TARG_PORT-1:0]  eligible;
  logic                    found;
  logic [LOG_N_TARG-1:0]   win_idx;
  logic                    sel_valid;
  logic [LOG_N_TARG-1:0]   sel_idx;
  logic [N_TARG_PORT-1:0]  sel_onehot;

  function automatic logic [LOG_N_TARG-1:0] ptr_after(input logic [LOG_N_TARG-1:0] idx);
    return (idx == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : idx + LOG_N_TARG'(1);
  endfunction

  // Round-robin search from rr_ptr over the eligible requesters
  always_comb begin
    int cand;
    eligible = awvalid_i;
`ifdef AXI_AW_QOS_ARB_EN
    begin
      logic [QOS_W-1:0] max_qos;
      max_qos = '0;
      for (int i = 0; i < int'(N_TARG_PORT); i++) begin
        if (awvalid_i[i] && (awattr_i[i*AW_ATTR_W +: QOS_W] > max_qos))
          max_qos = awattr_i[i*AW_ATTR_W +: QOS_W];
      end
      for (int i = 0; i < int'(N_TARG_PORT); i++)
        eligible[i] = awvalid_i[i] && (awattr_i[i*AW_ATTR_W +: QOS_W] == max_qos);
    end
`endif
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < int'(N_TARG_PORT); k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= int'(N_TARG_PORT)) cand = cand - int'(N_TARG_PORT);
      if (!found && eligible[LOG_N_TARG'(cand)]) begin
        found   = 1'b1;
        win_idx = LOG_N_TARG'(cand);
      end
    end
  end

  // FSM next state; HOLD pins the selection to lock_idx until downstream accepts
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_idx_nxt = lock_idx;
    sel_valid    = 1'b0;
    sel_idx      = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (grant_FIFO_ID_i && found) begin
            sel_valid = 1'b1;
            sel_idx   = win_idx;
            if (awready_i) begin
              rr_ptr_nxt = ptr_after(win_idx);
            end else begin
              lock_idx_nxt = win_idx;
              state_nxt    = HOLD;
            end
          end
        end
        HOLD: begin
          sel_valid = 1'b1;
          sel_idx   = lock_idx;
          if (awready_i) begin
            rr_ptr_nxt = ptr_after(lock_idx);
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Payload mux; everything reads zero when nothing is presented
  always_comb begin
    sel_onehot = '0;
    awid_o     = '0;
    awaddr_o   = '0;
    awlen_o    = '0;
    awattr_o   = '0;
    awuser_o   = '0;
    for (int i = 0; i < int'(N_TARG_PORT); i++) begin
      if (sel_valid && (sel_idx == LOG_N_TARG'(i))) begin
        sel_onehot[i] = 1'b1;
        awid_o        = awid_i[i*AXI_ID_W +: AXI_ID_W];
        awaddr_o      = awaddr_i[i*AXI_ADDRESS_W +: AXI_ADDRESS_W];
        awlen_o       = awlen_i[i*8 +: 8];
        awattr_o      = awattr_i[i*AW_ATTR_W +: AW_ATTR_W];
        awuser_o      = awuser_i[i*AXI_USER_W +: AXI_USER_W];
      end
    end
  end

  assign awvalid_o = sel_valid;
  assign push_ID_o = sel_valid & awready_i;
  assign awready_o = push_ID_o ? sel_onehot : '0;
  assign ID_o      = {sel_idx, sel_onehot};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

endmodule

// File: tb/tb_axi_aw_rr_allocator.sv
// Self-checking bench for axi_aw_rr_allocator (5 ports, non-power-of-two) against a queue-free behavioural model.
module tb_axi_aw_rr_allocator;

  localparam int N   = 5;
  localparam int LG  = 3;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int UW  = 6;
  localparam int ATW = 21;
  localparam int PW  = IDW + AW + 8 + ATW + UW;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*IDW-1:0] awid_i;
  logic [N*AW-1:0]  awaddr_i;
  logic [N*8-1:0]   awlen_i;
  logic [N*ATW-1:0] awattr_i;
  logic [N*UW-1:0]  awuser_i;
  logic [N-1:0]     awvalid_i;
  logic [N-1:0]     awready_o;
  logic [IDW-1:0]   awid_o;
  logic [AW-1:0]    awaddr_o;
  logic [7:0]       awlen_o;
  logic [ATW-1:0]   awattr_o;
  logic [UW-1:0]    awuser_o;
  logic             awvalid_o;
  logic             awready_i;
  logic             push_ID_o;
  logic [LG+N-1:0]  ID_o;
  logic             grant_FIFO_ID_i;

  always #5 clk = ~clk;

  axi_aw_rr_allocator #(
    .AXI_ADDRESS_W(AW), .AXI_ID_W(IDW), .AXI_USER_W(UW),
    .N_TARG_PORT(N), .LOG_N_TARG(LG), .AW_ATTR_W(ATW)
  ) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awattr_i(awattr_i),
    .awuser_i(awuser_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awattr_o(awattr_o),
    .awuser_o(awuser_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .push_ID_o(push_ID_o), .ID_o(ID_o), .grant_FIFO_ID_i(grant_FIFO_ID_i)
  );

  int errors = 0;
  int checks = 0;

  // Model state: priority pointer and an optional locked port awaiting acceptance
  int m_ptr  = 0;
  bit m_hold = 1'b0;
  int m_lock = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qos_of(input int p);
    logic [3:0] q;
    q = awattr_i[p*ATW +: 4];
    return int'(q);
  endfunction

  // First eligible requester counting upward from m_ptr, or -1 if none
  function automatic int pick();
    bit [N-1:0] elig;
    elig = awvalid_i;
`ifdef AXI_AW_QOS_ARB_EN
    begin
      int maxq;
      maxq = -1;
      for (int i = 0; i < N; i++)
        if (awvalid_i[i] && qos_of(i) > maxq) maxq = qos_of(i);
      for (int i = 0; i < N; i++)
        elig[i] = awvalid_i[i] && (qos_of(i) == maxq);
    end
`endif
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (elig[p]) return p;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, clock, then advance the model.
  // want >= 0: that port must be presented; -1: nothing presented; -2: model only.
  task automatic step(input string tag, input int want);
    bit             exp_valid;
    int             exp_sel;
    logic [N-1:0]   oh;
    logic [N-1:0]   woh;
    logic [PW-1:0]  exp_pay;
    logic [LG+N-1:0] exp_id;
    bit             exp_push;
    #1;
    exp_valid = 1'b0;
    exp_sel   = 0;
    if (!rst) begin
      if (m_hold) begin
        exp_valid = 1'b1;
        exp_sel   = m_lock;
      end else if (grant_FIFO_ID_i) begin
        int p;
        p = pick();
        if (p >= 0) begin
          exp_valid = 1'b1;
          exp_sel   = p;
        end
      end
    end
    oh = '0;
    if (exp_valid) oh[exp_sel] = 1'b1;
    exp_push = exp_valid && awready_i;
    exp_id   = {LG'(exp_sel), oh};
    exp_pay  = '0;
    if (exp_valid)
      exp_pay = {awid_i[exp_sel*IDW +: IDW], awaddr_i[exp_sel*AW +: AW], awlen_i[exp_sel*8 +: 8],
                 awattr_i[exp_sel*ATW +: ATW], awuser_i[exp_sel*UW +: UW]};
    check({tag, ".awvalid"}, 128'(awvalid_o), 128'(exp_valid));
    check({tag, ".awready"}, 128'(awready_o), 128'(exp_push ? oh : '0));
    check({tag, ".push"},    128'(push_ID_o), 128'(exp_push));
    check({tag, ".id"},      128'(ID_o),      128'(exp_id));
    check({tag, ".payload"}, 128'({awid_o, awaddr_o, awlen_o, awattr_o, awuser_o}), 128'(exp_pay));
    if (want != -2) begin
      woh = '0;
      if (want >= 0) woh[want] = 1'b1;
      check({tag, ".want_valid"}, 128'(awvalid_o), 128'(want >= 0));
      check({tag, ".want_id"},    128'(ID_o), 128'((want >= 0) ? {LG'(want), woh} : '0));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_ptr  = 0;
      m_hold = 1'b0;
    end else if (exp_valid) begin
      if (awready_i) begin
        m_ptr  = (exp_sel + 1) % N;
        m_hold = 1'b0;
      end else begin
        m_hold = 1'b1;
        m_lock = exp_sel;
      end
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      awid_i[i*IDW +: IDW]  = IDW'($urandom);
      awaddr_i[i*AW +: AW]  = $urandom;
      awlen_i[i*8 +: 8]     = 8'($urandom);
      awattr_i[i*ATW +: ATW] = ATW'($urandom);
      awuser_i[i*UW +: UW]  = UW'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1; awvalid_i = '1; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1;
    rand_payload();

    // Reset holds every output low even with all ports requesting
    step("reset0", -1);
    step("reset1", -1);

    // Full rotation with wrap from the last port back to 0
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rand_payload();
      step("rr", i);
    end
    step("rr_wrap", 0);

    // Stall on port 2; a later request from port 0 must not steal the beat
    awvalid_i = 5'b00100; awready_i = 1'b0;
    for (int i = 0; i < 3; i++) step("stall", 2);
    awvalid_i = 5'b00101;
    rand_payload();
    step("stall_p0", 2);
    awready_i = 1'b1;
    step("stall_accept", 2);
    step("after_stall", 0);

    // FIFO full blocks presentation; grant makes it appear combinationally
    grant_FIFO_ID_i = 1'b0; awvalid_i = 5'b00100;
    step("fifo_full", -1);
    grant_FIFO_ID_i = 1'b1;
    step("fifo_grant", 2);

    // Reset while locked on port 1 clears lock and pointer
    awvalid_i = 5'b00010; awready_i = 1'b0;
    step("lock1", 1);
    rst = 1'b1;
    step("rst_hold", -1);
    rst = 1'b0; awvalid_i = 5'b10001; awready_i = 1'b1;
    step("post_rst", 0);

`ifdef AXI_AW_QOS_ARB_EN
    awvalid_i = 5'b01001;
    awattr_i[0*ATW +: 4] = 4'd2;
    awattr_i[3*ATW +: 4] = 4'd9;
    step("qos_hi", 3);
    rst = 1'b1;
    step("qos_rst", -1);
    rst = 1'b0;
    awattr_i[0*ATW +: 4] = 4'd9;
    step("qos_tie0", 0);
    step("qos_tie3", 3);
`endif

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rand_payload();
      awvalid_i       = N'($urandom);
      awready_i       = ($urandom_range(0, 3) != 0);
      grant_FIFO_ID_i = ($urandom_range(0, 4) != 0);
      rst             = ($urandom_range(0, 49) == 0);
      step("rand", -2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
